// File: rtl/rvmyth_pll_ctrl.sv
// PLL bring-up controller for the rvmyth core: enables the VCO, pulses the PLL reset,
// measures the feedback rate in fixed windows, and switches the core clock once lock is seen.
module rvmyth_pll_ctrl #(
  parameter int unsigned EN_SETTLE       = 16,
  parameter int unsigned RST_CYCLES      = 8,
  parameter int unsigned WIN             = 64,
  parameter int unsigned CNT_W           = 10,
  parameter int unsigned LOCK_WINDOWS    = 3,
  parameter int unsigned TIMEOUT_WINDOWS = 32,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             fb_pulse,
  input  logic [CNT_W-1:0] cnt_lo,
  input  logic [CNT_W-1:0] cnt_hi,
  output logic             en_vco,
  output logic             pll_reset,
  output logic             core_reset,
  output logic             clk_sel,
  output logic             locked,
  output logic             fail,
  output logic [2:0]       state,
  output logic [1:0]       retry_cnt,
  output logic [CNT_W-1:0] last_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENABLE  = 3'd1,
    S_PRST    = 3'd2,
    S_MEASURE = 3'd3,
    S_LOCKED  = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  localparam int unsigned PH_MAX = (EN_SETTLE > RST_CYCLES) ? EN_SETTLE : RST_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned STK_W  = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_WINDOWS + 1);

  localparam logic [PH_W-1:0]  EN_LAST   = PH_W'(EN_SETTLE - 1);
  localparam logic [PH_W-1:0]  RST_LAST  = PH_W'(RST_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN - 1);
  localparam logic [STK_W-1:0] STK_DONE  = STK_W'(LOCK_WINDOWS);
  localparam logic [TO_W-1:0]  TO_DONE   = TO_W'(TIMEOUT_WINDOWS);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [STK_W-1:0]   streak_q, streak_d;
  logic [TO_W-1:0]    tmo_q, tmo_d;
  logic [1:0]         retry_q, retry_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic               en_d, prst_d, core_d, sel_d, lock_d, fail_d;

  logic [CNT_W-1:0]   cnt_total;
  logic [STK_W-1:0]   streak_inc;
  logic [TO_W-1:0]    tmo_inc;
  logic               measuring, win_end, in_range;

  // Count for the current window including this cycle's pulse, saturating.
  assign cnt_total  = (pcnt_q == '1) ? pcnt_q : pcnt_q + CNT_W'(fb_pulse);
  assign measuring  = (state_q == S_MEASURE) || (state_q == S_LOCKED);
  assign win_end    = measuring && (win_q == WIN_LAST);
  assign in_range   = (cnt_total >= cnt_lo) && (cnt_total <= cnt_hi);
  assign streak_inc = streak_q + STK_W'(1);
  assign tmo_inc    = tmo_q + TO_W'(1);

  always_comb begin
    state_d  = state_q;
    ph_d     = '0;
    win_d    = '0;
    pcnt_d   = '0;
    streak_d = '0;
    tmo_d    = '0;
    retry_d  = retry_q;
    last_d   = last_q;

    // Window/pulse counters only run while measuring; everywhere else they sit at zero,
    // which also gives the clean start required on every PRST entry.
    if (measuring) begin
      win_d    = win_end ? '0 : win_q + WIN_W'(1);
      pcnt_d   = win_end ? '0 : cnt_total;
      streak_d = streak_q;
      tmo_d    = tmo_q;
      if (win_end) last_d = cnt_total;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ENABLE;
          retry_d = '0;
        end
      end
      S_ENABLE: begin
        if (ph_q == EN_LAST) state_d = S_PRST;
        else                 ph_d    = ph_q + PH_W'(1);
      end
      S_PRST: begin
        if (ph_q == RST_LAST) state_d = S_MEASURE;
        else                  ph_d    = ph_q + PH_W'(1);
      end
      S_MEASURE: begin
        if (win_end) begin
          streak_d = in_range ? streak_inc : '0;
          tmo_d    = tmo_inc;
          if (in_range && (streak_inc == STK_DONE)) begin
            state_d = S_LOCKED;
          end else if (tmo_inc == TO_DONE) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 2'd1;
              state_d = S_PRST;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
      end
      S_LOCKED: begin
        if (win_end && !in_range) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = S_PRST;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_FAIL: ;
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d = S_IDLE;
      retry_d = '0;
      ph_d    = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they change in the
  // same cycle the state register does.
  always_comb begin
    en_d   = 1'b0;
    prst_d = 1'b1;
    core_d = 1'b1;
    sel_d  = 1'b0;
    lock_d = 1'b0;
    fail_d = 1'b0;
    case (state_d)
      S_ENABLE:  begin en_d = 1'b1; prst_d = 1'b0; end
      S_PRST:    begin en_d = 1'b1; end
      S_MEASURE: begin en_d = 1'b1; prst_d = 1'b0; end
      S_LOCKED:  begin
        en_d   = 1'b1;
        prst_d = 1'b0;
        core_d = 1'b0;
        sel_d  = 1'b1;
        lock_d = 1'b1;
      end
      S_FAIL:    fail_d = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      win_q      <= '0;
      pcnt_q     <= '0;
      streak_q   <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      last_q     <= '0;
      en_vco     <= 1'b0;
      pll_reset  <= 1'b1;
      core_reset <= 1'b1;
      clk_sel    <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      win_q      <= win_d;
      pcnt_q     <= pcnt_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      last_q     <= last_d;
      en_vco     <= en_d;
      pll_reset  <= prst_d;
      core_reset <= core_d;
      clk_sel    <= sel_d;
      locked     <= lock_d;
      fail       <= fail_d;
    end
  end

  assign state      = state_q;
  assign retry_cnt  = retry_q;
  assign last_count = last_q;

endmodule

// File: tb/tb_rvmyth_pll_ctrl.sv
// Directed bench for rvmyth_pll_ctrl: expectations are queued as stimulus is applied
// and popped against the DUT outputs at each observation point.
module tb_rvmyth_pll_ctrl;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned SIG_STATE = 0;
  localparam int unsigned SIG_LOCK  = 1;
  localparam int unsigned SIG_LAST  = 2;
  localparam int unsigned SIG_RETRY = 3;
  localparam int unsigned SIG_FAIL  = 4;
  localparam int unsigned SIG_EN    = 5;
  localparam int unsigned SIG_PRST  = 6;
  localparam int unsigned SIG_CORE  = 7;
  localparam int unsigned SIG_SEL   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, stop, fb_pulse;
  logic [CNT_W-1:0] cnt_lo, cnt_hi;
  logic             en_vco, pll_reset, core_reset, clk_sel, locked, fail;
  logic [2:0]       state;
  logic [1:0]       retry_cnt;
  logic [CNT_W-1:0] last_count;

  typedef struct {
    string       tag;
    int unsigned sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  rvmyth_pll_ctrl #(
    .EN_SETTLE(16), .RST_CYCLES(8), .WIN(64), .CNT_W(CNT_W),
    .LOCK_WINDOWS(3), .TIMEOUT_WINDOWS(32), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .fb_pulse(fb_pulse),
    .cnt_lo(cnt_lo), .cnt_hi(cnt_hi), .en_vco(en_vco), .pll_reset(pll_reset),
    .core_reset(core_reset), .clk_sel(clk_sel), .locked(locked), .fail(fail),
    .state(state), .retry_cnt(retry_cnt), .last_count(last_count)
  );

  function automatic logic [15:0] observe(input int unsigned sig);
    case (sig)
      SIG_STATE: return 16'(state);
      SIG_LOCK:  return 16'(locked);
      SIG_LAST:  return 16'(last_count);
      SIG_RETRY: return 16'(retry_cnt);
      SIG_FAIL:  return 16'(fail);
      SIG_EN:    return 16'(en_vco);
      SIG_PRST:  return 16'(pll_reset);
      SIG_CORE:  return 16'(core_reset);
      SIG_SEL:   return 16'(clk_sel);
      default:   return 16'hdead;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned sig, input logic [15:0] exp);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic check_all;
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic push_idle(input string tag);
    push({tag, "_state"}, SIG_STATE, 16'd0);
    push({tag, "_en"},    SIG_EN,    16'd0);
    push({tag, "_prst"},  SIG_PRST,  16'd1);
    push({tag, "_core"},  SIG_CORE,  16'd1);
    push({tag, "_sel"},   SIG_SEL,   16'd0);
    push({tag, "_lock"},  SIG_LOCK,  16'd0);
    push({tag, "_fail"},  SIG_FAIL,  16'd0);
    push({tag, "_retry"}, SIG_RETRY, 16'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cmp("sel_vs_core_reset", 16'(clk_sel & core_reset), 16'd0);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Ticks until the DUT reaches target; tracks lock sightings and MEASURE->PRST retries.
  task automatic wait_state(input string tag, input logic [2:0] target, input int unsigned budget,
                            output int unsigned n, output bit saw_lock, output int unsigned retries);
    logic [2:0] prev;
    n = 0; saw_lock = 0; retries = 0;
    while (state !== target && n < budget) begin
      prev = state;
      tick();
      n++;
      if (locked === 1'b1) saw_lock = 1;
      if (prev == 3'd3 && state == 3'd2) retries++;
    end
    cmp({tag, "_reached"}, 16'(state), 16'(target));
  endtask

  int unsigned n, retries;
  bit          saw_lock;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; fb_pulse = 1'b0;
    cnt_lo = 10'd60; cnt_hi = 10'd68;
    run(3);
    push_idle("rst");
    push("rst_last", SIG_LAST, 16'd0);
    check_all();
    reset = 1'b0;
    run(2);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    push("startstop_state", SIG_STATE, 16'd0);
    run(1);
    check_all();
    start = 1'b0; stop = 1'b0;
    run(1);

    // Nominal bring-up: start in cycle N, fb every cycle, 60..68
    fb_pulse = 1'b1; start = 1'b1;
    push("n1_state", SIG_STATE, 16'd1);
    push("n1_en", SIG_EN, 16'd1);
    push("n1_prst", SIG_PRST, 16'd0);
    run(1); start = 1'b0; check_all();
    push("n16_state", SIG_STATE, 16'd1);
    run(15); check_all();
    push("n17_state", SIG_STATE, 16'd2);
    push("n17_prst", SIG_PRST, 16'd1);
    push("n17_en", SIG_EN, 16'd1);
    run(1); check_all();
    push("n24_state", SIG_STATE, 16'd2);
    run(7); check_all();
    push("n25_state", SIG_STATE, 16'd3);
    push("n25_prst", SIG_PRST, 16'd0);
    run(1); check_all();
    push("n216_state", SIG_STATE, 16'd3);
    push("n216_lock", SIG_LOCK, 16'd0);
    run(191); check_all();
    push("n217_state", SIG_STATE, 16'd4);
    push("n217_lock", SIG_LOCK, 16'd1);
    push("n217_sel", SIG_SEL, 16'd1);
    push("n217_core", SIG_CORE, 16'd0);
    push("n217_last", SIG_LAST, 16'd64);
    push("n217_retry", SIG_RETRY, 16'd0);
    run(1); check_all();

    // Lock loss: one full window with no feedback pulses
    fb_pulse = 1'b0;
    push("loss_pre_state", SIG_STATE, 16'd4);
    push("loss_pre_lock", SIG_LOCK, 16'd1);
    run(63); check_all();
    push("loss_state", SIG_STATE, 16'd2);
    push("loss_lock", SIG_LOCK, 16'd0);
    push("loss_sel", SIG_SEL, 16'd0);
    push("loss_core", SIG_CORE, 16'd1);
    push("loss_last", SIG_LAST, 16'd0);
    push("loss_retry", SIG_RETRY, 16'd1);
    run(1); check_all();

    // stop from MEASURE
    fb_pulse = 1'b1;
    wait_state("to_measure", 3'd3, 20, n, saw_lock, retries);
    cmp("prst_len", 16'(n), 16'd8);
    stop = 1'b1;
    push_idle("stop_meas");
    run(1); check_all();
    stop = 1'b0;

    // Asynchronous reset in the middle of MEASURE
    start = 1'b1; run(1); start = 1'b0;
    wait_state("to_measure2", 3'd3, 40, n, saw_lock, retries);
    push("pre_areset_last", SIG_LAST, 16'd64);
    push("pre_areset_state", SIG_STATE, 16'd3);
    run(64); check_all();
    #3 reset = 1'b1;
    #1;
    push_idle("areset");
    push("areset_last", SIG_LAST, 16'd0);
    check_all();
    run(1);
    reset = 1'b0;
    run(1);

    // No feedback at all: initial attempt + 3 retries, then FAIL
    fb_pulse = 1'b0;
    start = 1'b1; run(1); start = 1'b0;
    wait_state("nofb_fail", 3'd5, 9000, n, saw_lock, retries);
    cmp("nofb_cycles", 16'(n), 16'd8240);
    cmp("nofb_retries", 16'(retries), 16'd3);
    push("nofb_fail", SIG_FAIL, 16'd1);
    push("nofb_en", SIG_EN, 16'd0);
    push("nofb_prst", SIG_PRST, 16'd1);
    push("nofb_core", SIG_CORE, 16'd1);
    push("nofb_retry", SIG_RETRY, 16'd3);
    push("nofb_last", SIG_LAST, 16'd0);
    check_all();
    push("fail_sticky_state", SIG_STATE, 16'd5);
    push("fail_sticky_fail", SIG_FAIL, 16'd1);
    run(5); check_all();
    stop = 1'b1;
    push_idle("fail_stop");
    run(1); check_all();
    stop = 1'b0;

    // Inverted bounds: nothing is ever in range
    cnt_lo = 10'd70; cnt_hi = 10'd60; fb_pulse = 1'b1;
    start = 1'b1; run(1); start = 1'b0;
    wait_state("inv_fail", 3'd5, 9000, n, saw_lock, retries);
    cmp("inv_cycles", 16'(n), 16'd8240);
    cmp("inv_never_locked", 16'(saw_lock), 16'd0);
    push("inv_last", SIG_LAST, 16'd64);
    push("inv_fail", SIG_FAIL, 16'd1);
    check_all();
    stop = 1'b1; run(1); stop = 1'b0;

    // Inclusive bounds: lo == hi == exact count
    cnt_lo = 10'd64; cnt_hi = 10'd64;
    start = 1'b1; run(1); start = 1'b0;
    wait_state("edge_lock", 3'd4, 400, n, saw_lock, retries);
    cmp("edge_cycles", 16'(n), 16'd216);
    push("edge_lock", SIG_LOCK, 16'd1);
    push("edge_last", SIG_LAST, 16'd64);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
